move_predict: RTL and testbench

//  Registered move predictor for the 20x20 Tetris playfield; replaces the separate

---
 rtl/move_predict.sv | 136 +++++++++++++
 tb/tb_move_predict.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/move_predict.sv
// Registered move predictor for the 20x20 playfield: legality, resting check, and locked field with full rows cleared.
// Latency 1 cycle from validIn to validOut; no backpressure, one result per accepted request.
module move_predict (
    input  logic         clock,
    input  logic         reset,
    input  logic         validIn,
    input  logic [1:0]   moveSel,
    input  logic [0:399] fieldIn,
    input  logic [0:15]  block,
    input  logic [4:0]   blockX,
    input  logic [4:0]   blockY,
    output logic         validOut,
    output logic         ok,
    output logic         bottomTouch,
    output logic [4:0]   newX,
    output logic [4:0]   newY,
    output logic [0:399] newField,
    output logic [2:0]   score
);

    // Positions are widened to signed 8 bits so that column -1 is a wall hit rather than a wrap.
    function automatic logic collides(input logic [0:399] f, input logic [0:15] b,
                                      input logic signed [7:0] px, input logic signed [7:0] py);
        logic              hit;
        logic signed [7:0] x;
        logic signed [7:0] y;
        logic [8:0]        idx;
        hit = 1'b0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                x   = px + 8'(i);
                y   = py + 8'(j);
                idx = 9'(y) * 9'd20 + 9'(x);
                if (b[j*4+i]) begin
                    if (x < 0 || x > 19 || y < 0 || y > 19) hit = 1'b1;
                    else if (f[idx])                         hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    function automatic logic [0:399] place(input logic [0:399] f, input logic [0:15] b,
                                           input logic signed [7:0] px, input logic signed [7:0] py);
        logic [0:399]      r;
        logic signed [7:0] x;
        logic signed [7:0] y;
        logic [8:0]        idx;
        r = f;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                x   = px + 8'(i);
                y   = py + 8'(j);
                idx = 9'(y) * 9'd20 + 9'(x);
                if (b[j*4+i] && x >= 0 && x <= 19 && y >= 0 && y <= 19) r[idx] = 1'b1;
            end
        end
        return r;
    endfunction

    logic signed [7:0] bx, by, cand_x, cand_y, res_x, res_y;
    logic              ok_d, bottom_d;
    logic [0:399]      drawn;
    logic [19:0]       full;
    logic [4:0]        shift [20];
    logic [4:0]        n_full;
    logic [0:399]      field_d;

    logic              valid_q, ok_q, bottom_q;
    logic [4:0]        x_q, y_q;
    logic [0:399]      field_q;
    logic [2:0]        score_q;

    always_comb begin
        bx     = $signed({3'b000, blockX});
        by     = $signed({3'b000, blockY});
        cand_x = bx;
        cand_y = by;
        case (moveSel)
            2'b00:   cand_y = by + 8'sd1;
            2'b01:   cand_x = bx - 8'sd1;
            2'b10:   cand_x = bx + 8'sd1;
            default: ;
        endcase
        ok_d     = (moveSel != 2'b11) && !collides(fieldIn, block, cand_x, cand_y);
        res_x    = ok_d ? cand_x : bx;
        res_y    = ok_d ? cand_y : by;
        bottom_d = collides(fieldIn, block, res_x, res_y + 8'sd1);
        drawn    = place(fieldIn, block, res_x, res_y);
    end

    // Each surviving row r lands at r + (number of full rows below r).
    always_comb begin
        for (int r = 0; r < 20; r++) full[r] = &drawn[r*20 +: 20];
        shift[19] = 5'd0;
        for (int r = 18; r >= 0; r--) shift[r] = shift[r+1] + {4'b0000, full[r+1]};
        n_full  = shift[0] + {4'b0000, full[0]};
        field_d = '0;
        for (int d = 0; d < 20; d++) begin
            for (int r = 0; r < 20; r++) begin
                if (!full[r] && (5'(r) + shift[r] == 5'(d))) field_d[d*20 +: 20] = drawn[r*20 +: 20];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            ok_q     <= 1'b0;
            bottom_q <= 1'b0;
            x_q      <= 5'd0;
            y_q      <= 5'd0;
            field_q  <= '0;
            score_q  <= 3'd0;
        end else begin
            valid_q <= validIn;
            if (validIn) begin
                ok_q     <= ok_d;
                bottom_q <= bottom_d;
                x_q      <= res_x[4:0];
                y_q      <= res_y[4:0];
                field_q  <= field_d;
                score_q  <= n_full[2:0];
            end
        end
    end

    assign validOut    = valid_q;
    assign ok          = ok_q;
    assign bottomTouch = bottom_q;
    assign newX        = x_q;
    assign newY        = y_q;
    assign newField    = field_q;
    assign score       = score_q;

endmodule

// File: tb/tb_move_predict.sv
// Directed and randomised checks of move_predict against a grid-based reference model.
module tb_move_predict;

    logic         clock = 1'b0;
    logic         reset;
    logic         validIn;
    logic [1:0]   moveSel;
    logic [0:399] fieldIn;
    logic [0:15]  block;
    logic [4:0]   blockX, blockY;
    logic         validOut, ok, bottomTouch;
    logic [4:0]   newX, newY;
    logic [0:399] newField;
    logic [2:0]   score;

    move_predict dut (
        .clock(clock), .reset(reset), .validIn(validIn), .moveSel(moveSel),
        .fieldIn(fieldIn), .block(block), .blockX(blockX), .blockY(blockY),
        .validOut(validOut), .ok(ok), .bottomTouch(bottomTouch),
        .newX(newX), .newY(newY), .newField(newField), .score(score)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         ok;
        logic         bt;
        logic [4:0]   nx;
        logic [4:0]   ny;
        logic [2:0]   sc;
        logic [0:399] nf;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [0:15] shapes [6] = '{16'hCC00, 16'hF000, 16'h8888, 16'hE400, 16'h6C00, 16'h88C0};
    localparam logic [0:15] O_PIECE = 16'hCC00;

    function automatic bit tb_coll(input logic [0:399] f, input logic [0:15] b, input int px, input int py);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                if (b[j*4+i]) begin
                    if (px+i < 0 || px+i > 19 || py+j < 0 || py+j > 19) return 1'b1;
                    if (f[(py+j)*20 + px+i]) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic [0:399] f, input logic [0:15] b,
                                   input int bx, input int by, input logic [1:0] ms);
        exp_t e;
        int   cx, cy, rx, ry, dst, cnt;
        bit   g [20][20];
        bit   rowfull;
        cx = bx;
        cy = by;
        if (ms == 2'b00) cy = by + 1;
        if (ms == 2'b01) cx = bx - 1;
        if (ms == 2'b10) cx = bx + 1;
        e.ok = (ms != 2'b11) && !tb_coll(f, b, cx, cy);
        rx   = e.ok ? cx : bx;
        ry   = e.ok ? cy : by;
        e.bt = tb_coll(f, b, rx, ry + 1);
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 20; x++) g[y][x] = f[y*20+x];
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                if (b[j*4+i] && rx+i >= 0 && rx+i <= 19 && ry+j >= 0 && ry+j <= 19) g[ry+j][rx+i] = 1'b1;
        e.nf = '0;
        dst  = 19;
        cnt  = 0;
        for (int y = 19; y >= 0; y--) begin
            rowfull = 1'b1;
            for (int x = 0; x < 20; x++) if (!g[y][x]) rowfull = 1'b0;
            if (rowfull) cnt++;
            else begin
                for (int x = 0; x < 20; x++) e.nf[dst*20+x] = g[y][x];
                dst--;
            end
        end
        e.nx = rx[4:0];
        e.ny = ry[4:0];
        e.sc = cnt[2:0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_result();
        exp_t e;
        e    = sb.pop_front();
        last = e;
        chk("validOut", 400'(validOut), 400'(1'b1));
        chk("ok", 400'(ok), 400'(e.ok));
        chk("bottomTouch", 400'(bottomTouch), 400'(e.bt));
        chk("newX", 400'(newX), 400'(e.nx));
        chk("newY", 400'(newY), 400'(e.ny));
        chk("score", 400'(score), 400'(e.sc));
        chk("newField", 400'(newField), 400'(e.nf));
    endtask

    // Drive at posedge+1; result is registered on the next edge and sampled 1 time unit later.
    task automatic req(input logic [0:399] f, input logic [0:15] b, input int x, input int y, input logic [1:0] m);
        fieldIn = f;
        block   = b;
        blockX  = 5'(x);
        blockY  = 5'(y);
        moveSel = m;
        validIn = 1'b1;
        sb.push_back(model(f, b, x, y, m));
        @(posedge clock);
        #1;
        check_result();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_validOut"}, 400'(validOut), 400'(1'b0));
        chk({tag, "_ok"}, 400'(ok), 400'(1'b0));
        chk({tag, "_bottomTouch"}, 400'(bottomTouch), 400'(1'b0));
        chk({tag, "_newX"}, 400'(newX), 400'(5'd0));
        chk({tag, "_newY"}, 400'(newY), 400'(5'd0));
        chk({tag, "_score"}, 400'(score), 400'(3'd0));
        chk({tag, "_newField"}, 400'(newField), 400'(0));
    endtask

    initial begin
        logic [0:399] f;
        int           c, x, y;

        reset   = 1'b1;
        validIn = 1'b0;
        moveSel = 2'b00;
        fieldIn = '0;
        block   = '0;
        blockX  = 5'd0;
        blockY  = 5'd0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;

        // O-piece falls freely on an empty field
        f = '0;
        req(f, O_PIECE, 8, 0, 2'b00);
        chk("o_down_ok", 400'(ok), 400'(1'b1));
        chk("o_down_newY", 400'(newY), 400'(5'd1));
        chk("o_down_bt", 400'(bottomTouch), 400'(1'b0));

        // O-piece on the floor
        req(f, O_PIECE, 8, 18, 2'b00);
        chk("floor_ok", 400'(ok), 400'(1'b0));
        chk("floor_bt", 400'(bottomTouch), 400'(1'b1));
        chk("floor_bit368", 400'(newField[368]), 400'(1'b1));
        chk("floor_bit389", 400'(newField[389]), 400'(1'b1));

        // Walls
        req(f, O_PIECE, 0, 5, 2'b01);
        chk("left_wall_newX", 400'(newX), 400'(5'd0));
        chk("left_wall_ok", 400'(ok), 400'(1'b0));
        req(f, O_PIECE, 18, 5, 2'b10);
        chk("right_wall_newX", 400'(newX), 400'(5'd18));
        req(f, O_PIECE, 17, 5, 2'b10);
        chk("right_ok_newX", 400'(newX), 400'(5'd18));

        // Blocked left by a field cell
        f = '0;
        f[7] = 1'b1;
        req(f, O_PIECE, 8, 0, 2'b01);
        chk("cell_block_ok", 400'(ok), 400'(1'b0));

        // Row 19 nearly full; landing clears it and row 18 drops down
        f = '0;
        for (int i = 0; i < 20; i++) if (i != 8 && i != 9) f[380+i] = 1'b1;
        f[360] = 1'b1;
        f[375] = 1'b1;
        req(f, O_PIECE, 8, 18, 2'b00);
        chk("clear_score", 400'(score), 400'(3'd1));
        chk("clear_bt", 400'(bottomTouch), 400'(1'b1));
        chk("clear_row19", 400'(newField[380 +: 20]), 400'(20'b1000_0000_1100_0001_0000));
        chk("clear_row0", 400'(newField[0 +: 20]), 400'(20'd0));

        // Reserved move code still locks the piece where it is
        req(f, O_PIECE, 8, 18, 2'b11);
        chk("reserved_ok", 400'(ok), 400'(1'b0));
        chk("reserved_score", 400'(score), 400'(3'd1));

        // Empty piece never collides
        req(f, 16'h0000, 5, 19, 2'b00);
        chk("empty_ok", 400'(ok), 400'(1'b1));
        chk("empty_bt", 400'(bottomTouch), 400'(1'b0));

        // Idle cycle: no pulse, outputs hold
        validIn = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_validOut", 400'(validOut), 400'(1'b0));
        chk("idle_hold_ok", 400'(ok), 400'(last.ok));
        chk("idle_hold_newY", 400'(newY), 400'(last.ny));
        chk("idle_hold_field", 400'(newField), 400'(last.nf));

        // Back-to-back randomised requests
        for (int k = 0; k < 40; k++) begin
            f = '0;
            for (int yy = 8; yy < 20; yy++)
                for (int xx = 0; xx < 20; xx++)
                    if ($urandom_range(0, 3) == 0) f[yy*20+xx] = 1'b1;
            c = $urandom_range(0, 18);
            if (k % 3 == 0)
                for (int yy = 18; yy < 20; yy++)
                    for (int xx = 0; xx < 20; xx++) f[yy*20+xx] = (xx != c && xx != c + 1);
            x = (k % 3 == 0) ? c : $urandom_range(0, 18);
            y = (k % 3 == 0) ? $urandom_range(14, 18) : $urandom_range(0, 17);
            req(f, shapes[$urandom_range(0, 5)], x, y, 2'($urandom_range(0, 3)));
        end

        // Reset in the middle of a request clears everything immediately and drops the request
        f = '0;
        req(f, O_PIECE, 8, 18, 2'b00);
        fieldIn = f;
        block   = O_PIECE;
        blockX  = 5'd3;
        blockY  = 5'd3;
        moveSel = 2'b00;
        validIn = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid");
        @(posedge clock);
        #1;
        check_all_zero("reset_held");
        reset   = 1'b0;
        validIn = 1'b0;
        @(posedge clock);
        #1;
        chk("post_reset_validOut", 400'(validOut), 400'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
